conv_window_sequencer: RTL and testbench

- Upstream control and data stage for the 3x3x3 MACC filter unit. Feeds its `image_pixel`, `frow`, `fcol`, `fdep` and `rst` inputs.
- Walks a 6x6x3 image stored in a synchronous-read pixel RAM. Issues the 27 taps of each of the 16 stride-1 output positions (4x4 map).
- Captures the MACC accumulator result after each window and emits one activation per position with its (row, col) index.

---
 rtl/conv_window_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - 3x3x3 window walker feeding a MACC over a 6x6x3 image, 4x4 activation map
// Optional ReLU clamp on captured activations: CONV_WINDOW_SEQUENCER_RELU_EN
module conv_window_sequencer #(
    parameter int IMG_DIM      = 6,
    parameter int FILT_DIM     = 3,
    parameter int DEPTH        = 3,
    parameter int RAM_LATENCY  = 1,
    parameter int MACC_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [6:0]  pix_addr,
    input  logic [17:0] mem_rdata,
    output logic [17:0] image_pixel,
    output logic [1:0]  frow,
    output logic [1:0]  fcol,
    output logic [1:0]  fdep,
    output logic        macc_rst,
    input  logic [47:0] activation,
    output logic [47:0] act_out,
    output logic        act_valid,
    output logic [1:0]  act_row,
    output logic [1:0]  act_col
);

    localparam int         OUT_DIM    = IMG_DIM - FILT_DIM + 1;
    localparam logic [1:0] FMAX       = 2'(FILT_DIM - 1);
    localparam logic [1:0] DMAX       = 2'(DEPTH - 1);
    localparam logic [1:0] OMAX       = 2'(OUT_DIM - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(MACC_LATENCY);
    localparam logic [6:0] IMG_W      = 7'(IMG_DIM);
    localparam logic [6:0] DEP_W      = 7'(DEPTH);

    if (RAM_LATENCY != 1) begin : g_ram_latency_check
        $error("conv_window_sequencer: only RAM_LATENCY=1 is supported");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_EMIT
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_orow, r_ocol;
    logic [1:0]  r_fr, r_fc, r_fd;
    logic [3:0]  r_drain;
    logic [6:0]  r_addr_hold;
    logic [1:0]  r_frow, r_fcol, r_fdep;
    logic        r_tap_valid;
    logic        r_macc_rst;
    logic [47:0] r_act_out;
    logic        r_act_valid;
    logic [1:0]  r_act_row, r_act_col;
    logic        r_done;

    logic        w_start_ok;
    logic        w_last_tap;
    logic        w_last_pos;
    logic        w_drain_done;
    logic [6:0]  w_img_r, w_img_c;
    logic [6:0]  w_addr;
    logic [47:0] w_act_next;

    // busy stays up through the done cycle so a start coincident with done is ignored
    assign busy         = (r_state != S_IDLE) || r_done;
    assign w_start_ok   = start && !busy;
    assign w_last_tap   = (r_fr == FMAX) && (r_fc == FMAX) && (r_fd == DMAX);
    assign w_last_pos   = (r_orow == OMAX) && (r_ocol == OMAX);
    assign w_drain_done = (r_drain == DRAIN_LAST);

    assign w_img_r = {5'd0, r_orow} + {5'd0, r_fr};
    assign w_img_c = {5'd0, r_ocol} + {5'd0, r_fc};
    assign w_addr  = (w_img_r * IMG_W + w_img_c) * DEP_W + {5'd0, r_fd};

    always_comb begin
`ifdef CONV_WINDOW_SEQUENCER_RELU_EN
        w_act_next = activation[47] ? 48'd0 : activation;
`else
        w_act_next = activation;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_CLEAR;
            S_CLEAR: w_next = S_RUN;
            S_RUN:   if (w_last_tap) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_next = S_EMIT;
            S_EMIT:  w_next = w_last_pos ? S_IDLE : S_CLEAR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_orow      <= '0;
            r_ocol      <= '0;
            r_fr        <= '0;
            r_fc        <= '0;
            r_fd        <= '0;
            r_drain     <= '0;
            r_addr_hold <= '0;
            r_frow      <= '0;
            r_fcol      <= '0;
            r_fdep      <= '0;
            r_tap_valid <= 1'b0;
            r_macc_rst  <= 1'b0;
            r_act_out   <= '0;
            r_act_valid <= 1'b0;
            r_act_row   <= '0;
            r_act_col   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_act_valid <= 1'b0;
            r_done      <= 1'b0;
            // MACC-side controls trail the address by one cycle to line up with RAM data
            r_tap_valid <= (r_state == S_RUN);
            r_macc_rst  <= (r_state == S_CLEAR);
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_orow <= '0;
                        r_ocol <= '0;
                    end
                end
                S_CLEAR: begin
                    r_fr    <= '0;
                    r_fc    <= '0;
                    r_fd    <= '0;
                    r_drain <= '0;
                end
                S_RUN: begin
                    r_addr_hold <= w_addr;
                    r_frow      <= r_fr;
                    r_fcol      <= r_fc;
                    r_fdep      <= r_fd;
                    if (r_fd == DMAX) begin
                        r_fd <= '0;
                        if (r_fc == FMAX) begin
                            r_fc <= '0;
                            r_fr <= r_fr + 2'd1;
                        end else begin
                            r_fc <= r_fc + 2'd1;
                        end
                    end else begin
                        r_fd <= r_fd + 2'd1;
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 4'd1;
                end
                S_EMIT: begin
                    r_act_out   <= w_act_next;
                    r_act_row   <= r_orow;
                    r_act_col   <= r_ocol;
                    r_act_valid <= 1'b1;
                    r_done      <= w_last_pos;
                    if (r_ocol == OMAX) begin
                        r_ocol <= '0;
                        r_orow <= r_orow + 2'd1;
                    end else begin
                        r_ocol <= r_ocol + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_addr    = (r_state == S_RUN) ? w_addr : r_addr_hold;
    assign image_pixel = r_tap_valid ? mem_rdata : 18'd0;
    assign frow        = r_frow;
    assign fcol        = r_fcol;
    assign fdep        = r_fdep;
    assign macc_rst    = r_macc_rst;
    assign act_out     = r_act_out;
    assign act_valid   = r_act_valid;
    assign act_row     = r_act_row;
    assign act_col     = r_act_col;
    assign done        = r_done;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - directed bench with pixel RAM and MACC models for conv_window_sequencer
module tb_conv_window_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [6:0]  pix_addr;
    logic [17:0] mem_rdata;
    logic [17:0] image_pixel;
    logic [1:0]  frow, fcol, fdep;
    logic        macc_rst;
    logic [47:0] activation;
    logic [47:0] act_out;
    logic        act_valid;
    logic [1:0]  act_row, act_col;

`ifdef CONV_WINDOW_SEQUENCER_RELU_EN
    localparam logic [47:0] EXP_NEG = 48'd0;
`else
    localparam logic [47:0] EXP_NEG = 48'hFFFF_FFFF_FEA1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [17:0]        ram [0:127];
    logic signed [47:0] acc = '0;

    int          q_cyc[$];
    logic [47:0] q_out[$];
    logic [1:0]  q_row[$];
    logic [1:0]  q_col[$];
    int          q_done[$];

    conv_window_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pix_addr   (pix_addr),
        .mem_rdata  (mem_rdata),
        .image_pixel(image_pixel),
        .frow       (frow),
        .fcol       (fcol),
        .fdep       (fdep),
        .macc_rst   (macc_rst),
        .activation (activation),
        .act_out    (act_out),
        .act_valid  (act_valid),
        .act_row    (act_row),
        .act_col    (act_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_rdata <= ram[pix_addr];

    // MACC with default filter: weight of tap (r,c,d) is 26 - (9r+3c+d)
    always @(posedge clk) begin
        if (macc_rst) acc <= '0;
        else acc <= acc + 48'($signed(image_pixel))
                        * 48'(26 - int'(frow) * 9 - int'(fcol) * 3 - int'(fdep));
    end
    assign activation = acc;

    always @(negedge clk) begin
        if (act_valid) begin
            q_cyc.push_back(cyc);
            q_out.push_back(act_out);
            q_row.push_back(act_row);
            q_col.push_back(act_col);
        end
        if (done) q_done.push_back(cyc);
    end

    task automatic fill(input logic [17:0] v);
        for (int i = 0; i < 128; i++) ram[i] = v;
    endtask

    task automatic clear_log;
        q_cyc.delete(); q_out.delete(); q_row.delete(); q_col.delete(); q_done.delete();
    endtask

    task automatic wait_until(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic do_start(output int t);
        @(posedge clk); #1;
        start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        fill(18'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({busy, done, act_valid, macc_rst} !== 4'b0) begin errors++;
            $display("FAIL reset_flags got %b exp 0000", {busy, done, act_valid, macc_rst}); end
        checks++; if (pix_addr !== 7'd0) begin errors++;
            $display("FAIL reset_pix_addr got %0d exp 0", pix_addr); end
        checks++; if (image_pixel !== 18'd0) begin errors++;
            $display("FAIL reset_image_pixel got %0h exp 0", image_pixel); end
        checks++; if ({frow, fcol, fdep, act_row, act_col} !== 10'd0) begin errors++;
            $display("FAIL reset_indices got %b exp 0", {frow, fcol, fdep, act_row, act_col}); end
        checks++; if (act_out !== 48'd0) begin errors++;
            $display("FAIL reset_act_out got %0h exp 0", act_out); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_address;
        int t, e, p;
        fill(18'd1); clear_log;
        do_start(t);
        wait_until(t + 1);
        checks++; if (busy !== 1'b1 || macc_rst !== 1'b0) begin errors++;
            $display("FAIL clear_cycle busy/macc_rst got %b%b exp 10", busy, macc_rst); end
        for (int k = 0; k < 27; k++) begin
            wait_until(t + 2 + k);
            e = (k / 9) * 18 + ((k / 3) % 3) * 3 + k % 3;
            checks++; if (pix_addr !== 7'(e)) begin errors++;
                $display("FAIL addr_tap%0d got %0d exp %0d", k, pix_addr, e); end
            if (k == 0) begin
                checks++; if (macc_rst !== 1'b1 || image_pixel !== 18'd0) begin errors++;
                    $display("FAIL first_tap macc_rst/pixel got %b/%0h exp 1/0", macc_rst, image_pixel); end
            end else begin
                p = k - 1;
                checks++; if ({frow, fcol, fdep} !== {2'(p / 9), 2'((p / 3) % 3), 2'(p % 3)}
                              || image_pixel !== 18'd1 || macc_rst !== 1'b0) begin errors++;
                    $display("FAIL align_tap%0d got f=%0d,%0d,%0d px=%0h mr=%b exp f=%0d,%0d,%0d px=1 mr=0",
                             p, frow, fcol, fdep, image_pixel, macc_rst, p / 9, (p / 3) % 3, p % 3); end
            end
        end
        wait_until(t + 29);
        checks++; if (pix_addr !== 7'd44 || image_pixel !== 18'd1 || {frow, fcol, fdep} !== 6'b101010) begin errors++;
            $display("FAIL last_tap_align got addr=%0d px=%0h f=%b exp 44/1/101010", pix_addr, image_pixel, {frow, fcol, fdep}); end
        wait_until(t + 30);
        checks++; if (pix_addr !== 7'd44 || image_pixel !== 18'd0) begin errors++;
            $display("FAIL drain_hold got addr=%0d px=%0h exp 44/0", pix_addr, image_pixel); end
        wait_until(t + 33);
        checks++; if (pix_addr !== 7'd3) begin errors++;
            $display("FAIL window1_start got %0d exp 3", pix_addr); end
        wait_until(t + 467);
        checks++; if (pix_addr !== 7'd63) begin errors++;
            $display("FAIL window15_start got %0d exp 63", pix_addr); end
        wait_until(t + 500);
    endtask

    task automatic test_all_ones_timing;
        int t;
        fill(18'd1); clear_log;
        do_start(t);
        wait_until(t + 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %b exp 1", busy); end
        wait_until(t + 497);
        checks++; if ({done, act_valid, busy} !== 3'b111) begin errors++;
            $display("FAIL final_cycle done/valid/busy got %b exp 111", {done, act_valid, busy}); end
        wait_until(t + 498);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL busy_fall busy/done got %b%b exp 00", busy, done); end
        checks++; if (q_cyc.size() != 16) begin errors++;
            $display("FAIL act_count got %0d exp 16", q_cyc.size()); end
        for (int i = 0; i < 16 && i < q_cyc.size(); i++) begin
            checks++; if (q_cyc[i] != t + 32 + 31 * i || q_out[i] !== 48'd351
                          || q_row[i] !== 2'(i / 4) || q_col[i] !== 2'(i % 4)) begin errors++;
                $display("FAIL act%0d got cyc=+%0d out=%0h rc=%0d,%0d exp cyc=+%0d out=15f rc=%0d,%0d",
                         i, q_cyc[i] - t, q_out[i], q_row[i], q_col[i], 32 + 31 * i, i / 4, i % 4); end
        end
        checks++; if (q_done.size() != 1 || (q_done.size() == 1 && q_done[0] != t + 497)) begin errors++;
            $display("FAIL done_pulses got %0d exp 1 at +497", q_done.size()); end
    endtask

    task automatic test_negative;
        int t;
        fill(18'h3FFFF); clear_log;
        do_start(t);
        wait_until(t + 499);
        checks++; if (q_cyc.size() != 16) begin errors++;
            $display("FAIL neg_count got %0d exp 16", q_cyc.size()); end
        for (int i = 0; i < 16 && i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== EXP_NEG) begin errors++;
                $display("FAIL neg_act%0d got %0h exp %0h", i, q_out[i], EXP_NEG); end
        end
    endtask

    task automatic test_reset_mid_pass;
        int t;
        fill(18'd1); clear_log;
        do_start(t);
        wait_until(t + 99);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_until(t + 101);
        checks++; if ({busy, done, act_valid, macc_rst, frow, fcol, fdep, act_row, act_col} !== 14'd0
                      || pix_addr !== 7'd0 || image_pixel !== 18'd0 || act_out !== 48'd0) begin errors++;
            $display("FAIL abort_outputs got busy=%b addr=%0d px=%0h out=%0h exp all 0", busy, pix_addr, image_pixel, act_out); end
        wait_until(t + 600);
        checks++; if (q_cyc.size() != 3 || q_done.size() != 0) begin errors++;
            $display("FAIL abort_pulses got valid=%0d done=%0d exp 3/0", q_cyc.size(), q_done.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_restart;
        int t;
        fill(18'd1); clear_log;
        do_start(t);
        wait_until(t + 499);
        checks++; if (q_cyc.size() != 16 || q_done.size() != 1) begin errors++;
            $display("FAIL restart_count got valid=%0d done=%0d exp 16/1", q_cyc.size(), q_done.size()); end
        for (int i = 0; i < 16 && i < q_cyc.size(); i++) begin
            checks++; if (q_out[i] !== 48'd351 || q_row[i] !== 2'(i / 4) || q_col[i] !== 2'(i % 4)) begin errors++;
                $display("FAIL restart_act%0d got out=%0h rc=%0d,%0d exp 15f %0d,%0d",
                         i, q_out[i], q_row[i], q_col[i], i / 4, i % 4); end
        end
    endtask

    task automatic test_start_ignored;
        int t;
        fill(18'd1); clear_log;
        do_start(t);
        wait_until(t + 49);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_until(t + 495);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_until(t + 540);
        checks++; if (q_cyc.size() != 16 || q_done.size() != 1) begin errors++;
            $display("FAIL ignored_count got valid=%0d done=%0d exp 16/1", q_cyc.size(), q_done.size()); end
        for (int i = 0; i < 16 && i < q_cyc.size(); i++) begin
            checks++; if (q_cyc[i] != t + 32 + 31 * i || q_row[i] !== 2'(i / 4) || q_col[i] !== 2'(i % 4)) begin errors++;
                $display("FAIL ignored_act%0d got cyc=+%0d rc=%0d,%0d exp +%0d %0d,%0d",
                         i, q_cyc[i] - t, q_row[i], q_col[i], 32 + 31 * i, i / 4, i % 4); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_idle got busy=%b exp 0", busy); end
    endtask

    initial begin
        test_reset;
        test_address;
        test_all_ones_timing;
        test_negative;
        test_reset_mid_pass;
        test_restart;
        test_start_ignored;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
